ov7670_capture_dec: RTL

Parametrised OV7670 capture front-end that turns the camera's 8-bit two-byte RGB565 stream into one pixel word per write into a frame buffer.
- Generalises the fixed 640x480/320x240/160x120 capture to arbitrary integer horizontal and vertical decimation, a configurable output window and a selectable output format.
- Adds frame tracking with frame-start/frame-done pulses.
- Sits between the camera pins (pclk domain) and the frame-buffer write port.

---
 rtl/ov7670_capture_dec.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ov7670_capture_dec.sv
// ov7670_capture_dec: OV7670 RGB565 byte-stream capture front-end.
// Assembles two-byte pixels, applies integer X/Y decimation and an output
// window, and writes one pixel word per cycle into a frame buffer.
// Optional crop origin ports are enabled with the macro OV7670_CAP_CROP_EN.
module ov7670_capture_dec #(
    parameter int unsigned DEC_X   = 1,
    parameter int unsigned DEC_Y   = 1,
    parameter int unsigned OUT_W   = 640,
    parameter int unsigned OUT_H   = 480,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned PIX_FMT = 0,
    localparam int unsigned DOUT_W = (PIX_FMT != 0) ? 16 : 12
) (
    input  logic              pclk,
    input  logic              rst,
`ifdef OV7670_CAP_CROP_EN
    input  logic [9:0]        crop_x0,
    input  logic [9:0]        crop_y0,
`endif
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [DOUT_W-1:0] dout,
    output logic              we,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int unsigned XDW      = (DEC_X > 1) ? $clog2(DEC_X) : 1;
    localparam int unsigned YDW      = (DEC_Y > 1) ? $clog2(DEC_Y) : 1;
    localparam int unsigned CW       = $clog2(OUT_W + 1);
    localparam int unsigned RW       = $clog2(OUT_H + 1);
    localparam int unsigned ADDR_MAX = OUT_W * OUT_H - 1;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        VSYNC     = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   fs_nxt, fd_nxt;

    logic       vs_r, hr_r, vs_q, hr_q;
    logic [7:0] d_r, byte0;
    logic       phase;

    logic [XDW-1:0] xdec;
    logic [YDW-1:0] ydec;
    logic [CW-1:0]  ocol;
    logic [RW-1:0]  orow;

    logic              hr_rise, hr_fall, vs_rise, vs_fall;
    logic              pix_evt, store;
    logic              col_ok, line_ok;
    logic [15:0]       pix565;
    logic [DOUT_W-1:0] pix_out;

    // Register camera pins; keep one-cycle-old copies for edge detection
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_r <= 1'b0;
            hr_r <= 1'b0;
            d_r  <= 8'h00;
            vs_q <= 1'b0;
            hr_q <= 1'b0;
        end else begin
            vs_r <= vsync;
            hr_r <= href;
            d_r  <= d;
            vs_q <= vs_r;
            hr_q <= hr_r;
        end
    end

    assign hr_rise = hr_r & ~hr_q;
    assign hr_fall = ~hr_r & hr_q;
    assign vs_rise = vs_r & ~vs_q;
    assign vs_fall = ~vs_r & vs_q;

    // Byte phase tracking and first-byte latch; a dangling odd byte never forms a pixel
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            byte0 <= 8'h00;
        end else begin
            if (!hr_r) begin
                phase <= 1'b0;
            end else begin
                phase <= ~phase;
            end
            if (hr_r && !phase) begin
                byte0 <= d_r;
            end
        end
    end

    assign pix_evt = hr_r & phase;
    assign pix565  = {byte0, d_r};

    // Output pixel format selection
    generate
        if (PIX_FMT != 0) begin : g_rgb565
            assign pix_out = pix565;
        end else begin : g_rgb444
            assign pix_out = {pix565[15:12], pix565[10:7], pix565[4:1]};
        end
    endgenerate

`ifdef OV7670_CAP_CROP_EN
    logic [9:0] cx0_q, cy0_q, icol, iline;

    // Crop origin latched at frame start; input column/line position tracking
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cx0_q <= 10'd0;
            cy0_q <= 10'd0;
            icol  <= 10'd0;
            iline <= 10'd0;
        end else begin
            if (fs_nxt) begin
                cx0_q <= crop_x0;
                cy0_q <= crop_y0;
            end
            if (hr_rise) begin
                icol <= 10'd0;
            end else if (pix_evt && icol != 10'h3FF) begin
                icol <= icol + 10'd1;
            end
            if (state != ACTIVE) begin
                iline <= 10'd0;
            end else if (hr_fall && iline != 10'h3FF) begin
                iline <= iline + 10'd1;
            end
        end
    end

    assign col_ok  = (icol >= cx0_q);
    assign line_ok = (iline >= cy0_q);
`else
    assign col_ok  = 1'b1;
    assign line_ok = 1'b1;
`endif

    assign store = pix_evt && col_ok && line_ok
                && (xdec == '0) && (ydec == '0)
                && (ocol < CW'(OUT_W)) && (orow < RW'(OUT_H))
                && (state == ACTIVE) && !vs_r;

    // Per-line counters: horizontal decimation phase and stored-pixel column
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            xdec <= '0;
            ocol <= '0;
        end else begin
            if (hr_rise) begin
                xdec <= '0;
            end else if (pix_evt && col_ok) begin
                xdec <= (xdec == XDW'(DEC_X - 1)) ? '0 : xdec + XDW'(1);
            end
            if (hr_rise) begin
                ocol <= '0;
            end else if (store) begin
                ocol <= ocol + CW'(1);
            end
        end
    end

    // Per-frame counters: vertical decimation phase and stored-row count
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            ydec <= '0;
            orow <= '0;
        end else if (state != ACTIVE) begin
            ydec <= '0;
            orow <= '0;
        end else if (hr_fall && line_ok) begin
            ydec <= (ydec == YDW'(DEC_Y - 1)) ? '0 : ydec + YDW'(1);
            if ((ydec == '0) && (orow < RW'(OUT_H))) begin
                orow <= orow + RW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and frame pulse requests
    always_comb begin
        state_nxt = state;
        fs_nxt    = 1'b0;
        fd_nxt    = 1'b0;
        case (state)
            WAIT_SYNC: begin
                if (vs_r) begin
                    state_nxt = VSYNC;
                end
            end
            VSYNC: begin
                if (vs_fall) begin
                    fs_nxt    = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    fd_nxt    = 1'b1;
                    state_nxt = VSYNC;
                end
            end
            default: begin
                state_nxt = WAIT_SYNC;
            end
        endcase
    end

    // Registered write port and frame pulses; address advances after each write
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            dout        <= '0;
            we          <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            we          <= store;
            frame_start <= fs_nxt;
            frame_done  <= fd_nxt;
            if (store) begin
                dout <= pix_out;
            end
            if (state != ACTIVE) begin
                addr <= '0;
            end else if (we && (addr != ADDR_W'(ADDR_MAX))) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule
